// File: rtl/halt_ctrl.sv
// halt_ctrl: ebreak-driven halt sequencer with memory drain and
// simulation-end reporting, plus cycle/instret performance counters.
module halt_ctrl #(
    parameter int DRAIN_MAX = 16,
    parameter int CNT_W     = 64
) (
    input  logic             clock,
    input  logic             rst_n,
    input  logic             commit_valid,
    input  logic             commit_ebreak,
    input  logic [31:0]      a0_value,
    input  logic             lsu_busy,
    output logic             halt_req,
    output logic             ebreak_end,
    output logic [31:0]      exit_code,
    output logic             good_trap,
    output logic             drain_timeout,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instret_cnt
);

    localparam int DW = $clog2(DRAIN_MAX + 1);
    localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_MAX - 1);

    typedef enum logic [1:0] {
        RUN,
        DRAIN,
        DONE
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [DW-1:0] drain_cnt;
    logic          retire;
    logic          take_ebreak;
    logic          to_done;
    logic          forced;

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state <= RUN;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        retire      = 1'b0;
        take_ebreak = 1'b0;
        to_done     = 1'b0;
        forced      = 1'b0;
        unique case (state)
            RUN: begin
                retire = commit_valid;
                if (commit_valid && commit_ebreak) begin
                    take_ebreak = 1'b1;
                    state_nxt   = DRAIN;
                end
            end
            DRAIN: begin
                // an idle LSU wins over an expiring drain budget
                if (!lsu_busy) begin
                    to_done   = 1'b1;
                    state_nxt = DONE;
                end else if (drain_cnt == DRAIN_LAST) begin
                    to_done   = 1'b1;
                    forced    = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = DONE;
            end
            default: begin
                state_nxt = RUN;
            end
        endcase
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            halt_req      <= 1'b0;
            ebreak_end    <= 1'b0;
            exit_code     <= '0;
            good_trap     <= 1'b0;
            drain_timeout <= 1'b0;
            cycle_cnt     <= '0;
            instret_cnt   <= '0;
            drain_cnt     <= '0;
        end else begin
            halt_req   <= (state_nxt != RUN);
            ebreak_end <= (state_nxt == DONE);
            if (state != DONE) begin
                cycle_cnt <= cycle_cnt + CNT_W'(1);
            end
            if (retire) begin
                instret_cnt <= instret_cnt + CNT_W'(1);
            end
            if (take_ebreak) begin
                exit_code <= a0_value;
            end
            if (state == DRAIN) begin
                drain_cnt <= drain_cnt + DW'(1);
            end else begin
                drain_cnt <= '0;
            end
            // exit_code was captured on the ebreak edge, so it is stable here
            if (to_done) begin
                good_trap     <= (exit_code == 32'd0);
                drain_timeout <= forced;
            end
        end
    end

endmodule

// File: tb/tb_halt_ctrl.sv
// Directed bench for halt_ctrl: one task per scenario, inline checks,
// a second instance with CNT_W=4 for counter wrap.
module tb_halt_ctrl;

    logic        clock;
    logic        rst_n;
    logic        commit_valid;
    logic        commit_ebreak;
    logic [31:0] a0_value;
    logic        lsu_busy;

    logic        halt_req;
    logic        ebreak_end;
    logic [31:0] exit_code;
    logic        good_trap;
    logic        drain_timeout;
    logic [63:0] cycle_cnt;
    logic [63:0] instret_cnt;

    logic        w_halt_req;
    logic        w_ebreak_end;
    logic [31:0] w_exit_code;
    logic        w_good_trap;
    logic        w_drain_timeout;
    logic [3:0]  w_cycle_cnt;
    logic [3:0]  w_instret_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    halt_ctrl u_dut (
        .clock        (clock),
        .rst_n        (rst_n),
        .commit_valid (commit_valid),
        .commit_ebreak(commit_ebreak),
        .a0_value     (a0_value),
        .lsu_busy     (lsu_busy),
        .halt_req     (halt_req),
        .ebreak_end   (ebreak_end),
        .exit_code    (exit_code),
        .good_trap    (good_trap),
        .drain_timeout(drain_timeout),
        .cycle_cnt    (cycle_cnt),
        .instret_cnt  (instret_cnt)
    );

    halt_ctrl #(.DRAIN_MAX(16), .CNT_W(4)) u_wrap (
        .clock        (clock),
        .rst_n        (rst_n),
        .commit_valid (commit_valid),
        .commit_ebreak(commit_ebreak),
        .a0_value     (a0_value),
        .lsu_busy     (lsu_busy),
        .halt_req     (w_halt_req),
        .ebreak_end   (w_ebreak_end),
        .exit_code    (w_exit_code),
        .good_trap    (w_good_trap),
        .drain_timeout(w_drain_timeout),
        .cycle_cnt    (w_cycle_cnt),
        .instret_cnt  (w_instret_cnt)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        commit_valid  = 1'b0;
        commit_ebreak = 1'b0;
        a0_value      = 32'h0;
        lsu_busy      = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        @(posedge clock);
        #1 rst_n = 1'b0;
        #4;
        @(posedge clock);
        #1 rst_n = 1'b1;
    endtask

    task automatic commit_ebreak_now(input logic [31:0] a0, input logic busy);
        commit_valid  = 1'b1;
        commit_ebreak = 1'b1;
        a0_value      = a0;
        lsu_busy      = busy;
        cyc();
        commit_valid  = 1'b0;
        commit_ebreak = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle_inputs();
        #3;
        n_checks++; if (halt_req !== 1'b0) begin n_fail++; $display("FAIL rst_halt: got %0b want 0", halt_req); end
        n_checks++; if (ebreak_end !== 1'b0) begin n_fail++; $display("FAIL rst_end: got %0b want 0", ebreak_end); end
        n_checks++; if (exit_code !== 32'h0) begin n_fail++; $display("FAIL rst_exit: got %0h want 0", exit_code); end
        n_checks++; if (good_trap !== 1'b0) begin n_fail++; $display("FAIL rst_good: got %0b want 0", good_trap); end
        n_checks++; if (drain_timeout !== 1'b0) begin n_fail++; $display("FAIL rst_tmo: got %0b want 0", drain_timeout); end
        n_checks++; if (cycle_cnt !== 64'd0) begin n_fail++; $display("FAIL rst_cyc: got %0d want 0", cycle_cnt); end
        n_checks++; if (instret_cnt !== 64'd0) begin n_fail++; $display("FAIL rst_inst: got %0d want 0", instret_cnt); end
        do_reset();
        n_checks++; if (cycle_cnt !== 64'd0) begin n_fail++; $display("FAIL rel_cyc0: got %0d want 0", cycle_cnt); end
        cyc();
        n_checks++; if (cycle_cnt !== 64'd1) begin n_fail++; $display("FAIL rel_cyc1: got %0d want 1", cycle_cnt); end
        n_checks++; if (instret_cnt !== 64'd0) begin n_fail++; $display("FAIL rel_inst: got %0d want 0", instret_cnt); end
    endtask

    task automatic test_normal_halt();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            commit_valid  = 1'b1;
            commit_ebreak = 1'b0;
            a0_value      = 32'd100 + 32'(i);
            cyc();
        end
        n_checks++; if (instret_cnt !== 64'd5) begin n_fail++; $display("FAIL nh_inst5: got %0d want 5", instret_cnt); end
        n_checks++; if (halt_req !== 1'b0) begin n_fail++; $display("FAIL nh_run_halt: got %0b want 0", halt_req); end
        commit_ebreak_now(32'h0, 1'b0);
        n_checks++; if (halt_req !== 1'b1) begin n_fail++; $display("FAIL nh_halt: got %0b want 1", halt_req); end
        n_checks++; if (ebreak_end !== 1'b0) begin n_fail++; $display("FAIL nh_end_n1: got %0b want 0", ebreak_end); end
        n_checks++; if (instret_cnt !== 64'd6) begin n_fail++; $display("FAIL nh_inst6: got %0d want 6", instret_cnt); end
        cyc();
        n_checks++; if (ebreak_end !== 1'b1) begin n_fail++; $display("FAIL nh_end_n2: got %0b want 1", ebreak_end); end
        n_checks++; if (good_trap !== 1'b1) begin n_fail++; $display("FAIL nh_good: got %0b want 1", good_trap); end
        n_checks++; if (drain_timeout !== 1'b0) begin n_fail++; $display("FAIL nh_tmo: got %0b want 0", drain_timeout); end
        n_checks++; if (cycle_cnt !== 64'd7) begin n_fail++; $display("FAIL nh_cyc: got %0d want 7", cycle_cnt); end
        cyc();
        cyc();
        n_checks++; if (cycle_cnt !== 64'd7) begin n_fail++; $display("FAIL nh_cyc_hold: got %0d want 7", cycle_cnt); end
        n_checks++; if (ebreak_end !== 1'b1) begin n_fail++; $display("FAIL nh_sticky: got %0b want 1", ebreak_end); end
        n_checks++; if (halt_req !== 1'b1) begin n_fail++; $display("FAIL nh_halt_done: got %0b want 1", halt_req); end
    endtask

    task automatic test_busy_drain();
        do_reset();
        commit_ebreak_now(32'h1, 1'b1);
        n_checks++; if (instret_cnt !== 64'd1) begin n_fail++; $display("FAIL bd_inst: got %0d want 1", instret_cnt); end
        n_checks++; if (halt_req !== 1'b1) begin n_fail++; $display("FAIL bd_halt: got %0b want 1", halt_req); end
        for (int i = 0; i < 3; i++) begin
            cyc();
            n_checks++; if (ebreak_end !== 1'b0) begin n_fail++; $display("FAIL bd_early_end%0d: got %0b want 0", i, ebreak_end); end
        end
        lsu_busy = 1'b0;
        cyc();
        n_checks++; if (ebreak_end !== 1'b1) begin n_fail++; $display("FAIL bd_end: got %0b want 1", ebreak_end); end
        n_checks++; if (exit_code !== 32'h1) begin n_fail++; $display("FAIL bd_exit: got %0h want 1", exit_code); end
        n_checks++; if (good_trap !== 1'b0) begin n_fail++; $display("FAIL bd_good: got %0b want 0", good_trap); end
        n_checks++; if (drain_timeout !== 1'b0) begin n_fail++; $display("FAIL bd_tmo: got %0b want 0", drain_timeout); end
        n_checks++; if (cycle_cnt !== 64'd5) begin n_fail++; $display("FAIL bd_cyc: got %0d want 5", cycle_cnt); end
        repeat (3) cyc();
        n_checks++; if (cycle_cnt !== 64'd5) begin n_fail++; $display("FAIL bd_cyc_hold: got %0d want 5", cycle_cnt); end
    endtask

    task automatic test_ignore_commits();
        do_reset();
        commit_ebreak_now(32'hDEAD_BEEF, 1'b1);
        commit_valid  = 1'b1;
        commit_ebreak = 1'b1;
        a0_value      = 32'h0;
        cyc();
        cyc();
        commit_ebreak = 1'b0;
        lsu_busy      = 1'b0;
        cyc();
        n_checks++; if (ebreak_end !== 1'b1) begin n_fail++; $display("FAIL ic_end: got %0b want 1", ebreak_end); end
        repeat (3) cyc();
        commit_valid = 1'b0;
        n_checks++; if (instret_cnt !== 64'd1) begin n_fail++; $display("FAIL ic_inst: got %0d want 1", instret_cnt); end
        n_checks++; if (exit_code !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL ic_exit: got %0h want deadbeef", exit_code); end
        n_checks++; if (good_trap !== 1'b0) begin n_fail++; $display("FAIL ic_good: got %0b want 0", good_trap); end
        n_checks++; if (cycle_cnt !== 64'd4) begin n_fail++; $display("FAIL ic_cyc: got %0d want 4", cycle_cnt); end
    endtask

    task automatic test_drain_timeout();
        do_reset();
        commit_ebreak_now(32'h2, 1'b1);
        repeat (15) cyc();
        n_checks++; if (ebreak_end !== 1'b0) begin n_fail++; $display("FAIL to_end15: got %0b want 0", ebreak_end); end
        n_checks++; if (halt_req !== 1'b1) begin n_fail++; $display("FAIL to_halt: got %0b want 1", halt_req); end
        cyc();
        n_checks++; if (ebreak_end !== 1'b1) begin n_fail++; $display("FAIL to_end16: got %0b want 1", ebreak_end); end
        n_checks++; if (drain_timeout !== 1'b1) begin n_fail++; $display("FAIL to_tmo: got %0b want 1", drain_timeout); end
        n_checks++; if (exit_code !== 32'h2) begin n_fail++; $display("FAIL to_exit: got %0h want 2", exit_code); end
        n_checks++; if (cycle_cnt !== 64'd17) begin n_fail++; $display("FAIL to_cyc: got %0d want 17", cycle_cnt); end
        cyc();
        n_checks++; if (cycle_cnt !== 64'd17) begin n_fail++; $display("FAIL to_cyc_hold: got %0d want 17", cycle_cnt); end
        lsu_busy = 1'b0;
    endtask

    task automatic test_timeout_priority();
        do_reset();
        commit_ebreak_now(32'h0, 1'b1);
        repeat (15) cyc();
        lsu_busy = 1'b0;
        cyc();
        n_checks++; if (ebreak_end !== 1'b1) begin n_fail++; $display("FAIL pr_end: got %0b want 1", ebreak_end); end
        n_checks++; if (drain_timeout !== 1'b0) begin n_fail++; $display("FAIL pr_tmo: got %0b want 0", drain_timeout); end
        n_checks++; if (good_trap !== 1'b1) begin n_fail++; $display("FAIL pr_good: got %0b want 1", good_trap); end
    endtask

    task automatic test_async_reset();
        do_reset();
        commit_ebreak_now(32'h3, 1'b0);
        cyc();
        n_checks++; if (ebreak_end !== 1'b1) begin n_fail++; $display("FAIL ar_pre_end: got %0b want 1", ebreak_end); end
        @(posedge clock);
        #3 rst_n = 1'b0;
        #1;
        n_checks++; if (ebreak_end !== 1'b0) begin n_fail++; $display("FAIL ar_end: got %0b want 0", ebreak_end); end
        n_checks++; if (halt_req !== 1'b0) begin n_fail++; $display("FAIL ar_halt: got %0b want 0", halt_req); end
        n_checks++; if (exit_code !== 32'h0) begin n_fail++; $display("FAIL ar_exit: got %0h want 0", exit_code); end
        n_checks++; if (cycle_cnt !== 64'd0) begin n_fail++; $display("FAIL ar_cyc: got %0d want 0", cycle_cnt); end
        n_checks++; if (instret_cnt !== 64'd0) begin n_fail++; $display("FAIL ar_inst: got %0d want 0", instret_cnt); end
        #2;
        @(posedge clock);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            commit_valid = 1'b1;
            cyc();
        end
        commit_ebreak_now(32'h7, 1'b0);
        cyc();
        n_checks++; if (ebreak_end !== 1'b1) begin n_fail++; $display("FAIL ar2_end: got %0b want 1", ebreak_end); end
        n_checks++; if (instret_cnt !== 64'd3) begin n_fail++; $display("FAIL ar2_inst: got %0d want 3", instret_cnt); end
        n_checks++; if (exit_code !== 32'h7) begin n_fail++; $display("FAIL ar2_exit: got %0h want 7", exit_code); end
        n_checks++; if (good_trap !== 1'b0) begin n_fail++; $display("FAIL ar2_good: got %0b want 0", good_trap); end
        n_checks++; if (cycle_cnt !== 64'd4) begin n_fail++; $display("FAIL ar2_cyc: got %0d want 4", cycle_cnt); end
    endtask

    task automatic test_cnt_wrap();
        do_reset();
        repeat (17) cyc();
        n_checks++; if (w_cycle_cnt !== 4'd1) begin n_fail++; $display("FAIL wr_cyc: got %0d want 1", w_cycle_cnt); end
        n_checks++; if (cycle_cnt !== 64'd17) begin n_fail++; $display("FAIL wr_cyc64: got %0d want 17", cycle_cnt); end
        n_checks++; if (w_halt_req !== 1'b0) begin n_fail++; $display("FAIL wr_halt: got %0b want 0", w_halt_req); end
        commit_ebreak_now(32'h0, 1'b0);
        cyc();
        n_checks++; if (w_ebreak_end !== 1'b1) begin n_fail++; $display("FAIL wr_end: got %0b want 1", w_ebreak_end); end
        n_checks++; if (w_good_trap !== 1'b1) begin n_fail++; $display("FAIL wr_good: got %0b want 1", w_good_trap); end
        n_checks++; if (w_cycle_cnt !== 4'd3) begin n_fail++; $display("FAIL wr_cyc3: got %0d want 3", w_cycle_cnt); end
        n_checks++; if (w_instret_cnt !== 4'd1) begin n_fail++; $display("FAIL wr_inst: got %0d want 1", w_instret_cnt); end
    endtask

    initial begin
        test_reset();
        test_normal_halt();
        test_busy_drain();
        test_ignore_commits();
        test_drain_timeout();
        test_timeout_priority();
        test_async_reset();
        test_cnt_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/halt_ctrl.md
HALT_CTRL -- requirements
Module: halt_ctrl

Interface
REQ-001 SHALL have parameter DRAIN_MAX, default 16, the maximum number of cycles spent in DRAIN before a forced halt.
REQ-002 SHALL have parameter CNT_W, default 64, the width of the performance counters.
REQ-003 SHALL have port clock  input  1  single system clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port commit_valid  input  1  one instruction retires this cycle.
REQ-006 SHALL have port commit_ebreak  input  1  the retiring instruction is ebreak; ignored unless commit_valid=1.
REQ-007 SHALL have port a0_value  input  32  GPR x10 value as seen by the retiring instruction.
REQ-008 SHALL have port lsu_busy  input  1  a memory transaction is outstanding.
REQ-009 SHALL have port halt_req  output  1  stall request to fetch and commit.
REQ-010 SHALL have port ebreak_end  output  1  simulation-end flag for the testbench; sticky.
REQ-011 SHALL have port exit_code  output  32  a0 captured at ebreak.
REQ-012 SHALL have port good_trap  output  1  exit_code==0; meaningful only while ebreak_end=1.
REQ-013 SHALL have port drain_timeout  output  1  halt was forced by DRAIN_MAX expiry.
REQ-014 SHALL have port cycle_cnt  output  CNT_W  cycles since reset release.
REQ-015 SHALL have port instret_cnt  output  CNT_W  retired instructions, ebreak included.

Function
REQ-016 SHALL implement a three-state FSM: RUN, DRAIN, DONE.
REQ-017 In RUN, commit_valid=1 with commit_ebreak=1 SHALL load exit_code<=a0_value, increment instret_cnt, and move the FSM to DRAIN on the next edge.
REQ-018 halt_req SHALL be registered: 0 in RUN, and 1 from the first cycle in DRAIN through every cycle in DONE.
REQ-019 In RUN, commit_valid=1 with commit_ebreak=0 SHALL increment instret_cnt by 1.
REQ-020 In DRAIN and DONE, commit_valid SHALL be ignored: no count change and no new exit_code capture.
REQ-021 In DRAIN, a 0..DRAIN_MAX drain counter SHALL reset to 0 on entry and increment each cycle.
REQ-022 In DRAIN, lsu_busy=0 sampled on any edge SHALL move the FSM to DONE with drain_timeout=0.
REQ-023 In DRAIN, if the drain counter reaches DRAIN_MAX-1 while lsu_busy=1, the FSM SHALL move to DONE with drain_timeout=1.
REQ-024 If both DRAIN exit conditions hold on the same edge, lsu_busy=0 SHALL take priority and drain_timeout SHALL be 0.
REQ-025 Latency: an ebreak committed at cycle N with lsu_busy=0 at N+1 SHALL give ebreak_end=1 at N+2.
REQ-026 ebreak_end SHALL be registered, equal to (state==DONE), and held until reset.
REQ-027 good_trap SHALL be a register set on entry to DONE.
REQ-028 cycle_cnt SHALL increment every cycle in RUN and DRAIN and hold its value in DONE.
REQ-029 cycle_cnt and instret_cnt SHALL wrap modulo 2^CNT_W without a flag.
REQ-030 An ebreak on the first cycle after reset release SHALL be handled normally: instret_cnt=1, FSM goes to DRAIN.
REQ-031 The block SHALL NOT generate X on any output after reset; inputs are assumed driven when rst_n=1.

Reset
REQ-032 While rst_n=0, the block SHALL force state=RUN, halt_req=0, ebreak_end=0, exit_code=0, good_trap=0, drain_timeout=0, cycle_cnt=0, instret_cnt=0, and drain counter=0, asynchronously.
REQ-033 Reset asserted in DRAIN or DONE SHALL abort the halt immediately, with all outputs taking their reset values without waiting for a clock edge.
REQ-034 Counting SHALL begin on the first rising edge at which rst_n=1 is sampled.

Verification
REQ-035 Scenario: release reset; 5 normal commits; then ebreak with a0=0 and lsu_busy=0 -> instret_cnt=6, ebreak_end=1 two cycles after the ebreak, good_trap=1, drain_timeout=0.
REQ-036 Scenario: ebreak with a0=0x0000_0001 and lsu_busy=1 for 3 cycles -> DRAIN lasts 4 cycles, exit_code=1, good_trap=0, cycle_cnt frozen thereafter.
REQ-037 Scenario: ebreak with lsu_busy stuck at 1 and DRAIN_MAX=16 -> ebreak_end=1 after 16 DRAIN cycles, drain_timeout=1.
REQ-038 Scenario: commit_valid=1 pulses during DRAIN and DONE -> instret_cnt and exit_code unchanged.
REQ-039 Scenario: rst_n dropped mid-clock while ebreak_end=1 -> all outputs 0 before the next edge; after release, a fresh run produces a correct second halt.
REQ-040 Scenario: CNT_W=4 with 17 cycles before ebreak -> cycle_cnt wraps to 1, no other effect.
